huffman_decoder: RTL

//  Decoding end of the Huffman path: rebuilds the canonical codebook from the per-symbol code lengths

---
 rtl/huffman_decoder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/huffman_decoder.sv
// Canonical Huffman decoder: rebuilds first/base/symbol tables from per-symbol code lengths,
// then decodes a serial MSB-first bitstream into symbols with valid/ready handshakes on both sides.
module huffman_decoder #(
  parameter int NSYM   = 16,
  parameter int SYMW   = 4,
  parameter int MAXLEN = 15,
  parameter int LENW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            len_we,
  input  logic [SYMW-1:0] len_addr,
  input  logic [LENW-1:0] len_data,
  input  logic            build,
  output logic            busy,
  output logic            tbl_ready,
  input  logic            bit_valid,
  input  logic            bit_data,
  output logic            bit_ready,
  output logic            sym_valid,
  output logic [SYMW-1:0] sym_data,
  input  logic            sym_ready,
  output logic            err
);

  localparam int NLEN = 1 << LENW;
  localparam int CW   = SYMW + 1;
  localparam int FW   = MAXLEN + 1;
  localparam int IDXW = $clog2(((NSYM > MAXLEN) ? NSYM : MAXLEN) + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_FIRST,
    S_PLACE,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [LENW-1:0] len_q    [NSYM];
  logic [LENW-1:0] len_d    [NSYM];
  logic [CW-1:0]   cnt_q    [NLEN];
  logic [CW-1:0]   cnt_d    [NLEN];
  logic [FW-1:0]   first_q  [NLEN];
  logic [FW-1:0]   first_d  [NLEN];
  logic [CW-1:0]   base_q   [NLEN];
  logic [CW-1:0]   base_d   [NLEN];
  logic [CW-1:0]   offs_q   [NLEN];
  logic [CW-1:0]   offs_d   [NLEN];
  logic [SYMW-1:0] symtab_q [NSYM];
  logic [SYMW-1:0] symtab_d [NSYM];
  logic [FW-1:0]   code_q, code_d;
  logic [LENW-1:0] clen_q, clen_d;
  logic            sym_valid_q, sym_valid_d;
  logic [SYMW-1:0] sym_data_q, sym_data_d;
  logic            err_q, err_d;

  logic            busy_int;
  logic            ready_int;
  logic            bit_ready_int;
  logic            bit_hs;
  logic [SYMW-1:0] scan_sym;
  logic [LENW-1:0] scan_len;
  logic [LENW-1:0] lvl;
  logic [LENW-1:0] lvl_m1;
  logic [FW-1:0]   code_n;
  logic [LENW-1:0] clen_n;
  logic [FW-1:0]   diff;
  logic            hit;

  assign busy_int      = (state_q == S_COUNT) || (state_q == S_FIRST) || (state_q == S_PLACE);
  assign ready_int     = (state_q == S_READY);
  assign bit_ready_int = ready_int & ~sym_valid_q & ~err_q;
  assign bit_hs        = bit_valid & bit_ready_int;

  // COUNT spends its first cycle clearing, so symbol s is scanned when idx_q == s+1
  assign scan_sym = (state_q == S_COUNT) ? SYMW'(idx_q - IDXW'(1)) : SYMW'(idx_q);
  assign scan_len = len_q[scan_sym];
  assign lvl      = LENW'(idx_q);
  assign lvl_m1   = lvl - LENW'(1);

  assign code_n = FW'({code_q, bit_data});
  assign clen_n = clen_q + LENW'(1);
  assign diff   = code_n - first_q[clen_n];
  assign hit    = (code_n >= first_q[clen_n]) && (diff < FW'(cnt_q[clen_n]));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    base_d      = base_q;
    offs_d      = offs_q;
    symtab_d    = symtab_q;
    code_d      = code_q;
    clen_d      = clen_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    err_d       = err_q;

    if (len_we && !busy_int) begin
      len_d[len_addr] = len_data;
    end

    case (state_q)
      S_IDLE: begin
        if (build) begin
          state_d = S_COUNT;
          idx_d   = '0;
        end
      end

      S_COUNT: begin
        if (idx_q == '0) begin
          for (int k = 0; k < NLEN; k++) begin
            cnt_d[k]   = '0;
            offs_d[k]  = '0;
            first_d[k] = '0;
            base_d[k]  = '0;
          end
        end else if (scan_len != '0) begin
          cnt_d[scan_len] = cnt_q[scan_len] + CW'(1);
        end
        if (idx_q == IDXW'(NSYM)) begin
          state_d = S_FIRST;
          idx_d   = IDXW'(1);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_FIRST: begin
        first_d[lvl] = (first_q[lvl_m1] + FW'(cnt_q[lvl_m1])) << 1;
        base_d[lvl]  = base_q[lvl_m1] + cnt_q[lvl_m1];
        if (idx_q == IDXW'(MAXLEN)) begin
          state_d = S_PLACE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_PLACE: begin
        if (scan_len != '0) begin
          symtab_d[SYMW'(base_q[scan_len] + offs_q[scan_len])] = scan_sym;
          offs_d[scan_len] = offs_q[scan_len] + CW'(1);
        end
        if (idx_q == IDXW'(NSYM - 1)) begin
          state_d = S_READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_READY: begin
        if (build) begin
          state_d     = S_COUNT;
          idx_d       = '0;
          code_d      = '0;
          clen_d      = '0;
          sym_valid_d = 1'b0;
          err_d       = 1'b0;
        end else begin
          if (sym_valid_q && sym_ready) begin
            sym_valid_d = 1'b0;
          end
          if (bit_hs) begin
            if (hit) begin
              sym_data_d  = symtab_q[SYMW'(FW'(base_q[clen_n]) + diff)];
              sym_valid_d = 1'b1;
              code_d      = '0;
              clen_d      = '0;
            end else if (clen_n == LENW'(MAXLEN)) begin
              err_d  = 1'b1;
              code_d = '0;
              clen_d = '0;
            end else begin
              code_d = code_n;
              clen_d = clen_n;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      code_q      <= '0;
      clen_q      <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < NSYM; k++) begin
        len_q[k]    <= '0;
        symtab_q[k] <= '0;
      end
      for (int k = 0; k < NLEN; k++) begin
        cnt_q[k]   <= '0;
        first_q[k] <= '0;
        base_q[k]  <= '0;
        offs_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      base_q      <= base_d;
      offs_q      <= offs_d;
      symtab_q    <= symtab_d;
      code_q      <= code_d;
      clen_q      <= clen_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_int;
  assign tbl_ready = ready_int;
  assign bit_ready = bit_ready_int;
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign err       = err_q;

endmodule
